syndrome_stream_packer: RTL and testbench

Upstream host-side stage of the single-FPGA decoder. Accepts one measurement round per valid/ready handshake as a parallel bit vector and serializes it into the 8-bit message stream consumed by the decoder input FIFO: a one-time START_DECODING_MSG, then per decode block a MEASUREMENT_DATA_HEADER followed by GRID_WIDTH_U zero-padded rounds, LSB byte first. In non-streaming use it holds the next header until the result consumer signals that the decoder's report for the previous block has drained.

---
 rtl/syndrome_stream_packer_pkg.sv | 18 +
 rtl/syndrome_stream_packer_round_byte_serializer.sv | 31 +++
 rtl/syndrome_stream_packer.sv | 112 +++++++++++
 tb/tb_syndrome_stream_packer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/syndrome_stream_packer_pkg.sv
// syndrome_stream_packer_pkg: shared message bytes, packer FSM states and saturating add helper
package syndrome_stream_packer_pkg;
  localparam logic [7:0] START_DECODING_MSG = 8'hA0;
  localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'hA1;
  typedef enum logic [2:0] {
    ST_RST,
    ST_START,
    ST_HEADER,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_RESULT
  } state_t;
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
endpackage

// File: rtl/syndrome_stream_packer_round_byte_serializer.sv
// round_byte_serializer: zero-padded round shift register emitting LSB byte first with last-byte flag
module round_byte_serializer #(
  parameter int PU = 18,
  parameter int BYTES = (PU + 7) >> 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          shift,
  input  logic [PU-1:0] din,
  output logic [7:0]    byte_out,
  output logic          last
);
  localparam int BW = BYTES > 1 ? $clog2(BYTES) : 1;
  logic [8*BYTES-1:0] shreg_q, shreg_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  always_comb begin
    shreg_d = load ? (8*BYTES)'(din) : shift ? shreg_q >> 8 : shreg_q;
    byte_cnt_d = load ? '0 : shift ? byte_cnt_q + BW'(1) : byte_cnt_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      shreg_q <= '0;
      byte_cnt_q <= '0;
    end else begin
      shreg_q <= shreg_d;
      byte_cnt_q <= byte_cnt_d;
    end
  assign byte_out = shreg_q[7:0];
  assign last = byte_cnt_q == BW'(BYTES - 1);
endmodule

// File: rtl/syndrome_stream_packer.sv
// syndrome_stream_packer: serializes measurement rounds into the decoder byte stream (HELIOS_SYNDROME_COUNT_EN adds syndrome_count)
module syndrome_stream_packer
  import syndrome_stream_packer_pkg::*;
#(
  parameter int GRID_WIDTH_X = 6,
  parameter int GRID_WIDTH_Z = 3,
  parameter int GRID_WIDTH_U = 9,
  localparam int PU_PER_ROUND = GRID_WIDTH_X * GRID_WIDTH_Z,
  localparam int BYTES_PER_ROUND = (PU_PER_ROUND + 7) >> 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PU_PER_ROUND-1:0] round_data,
  input  logic                    round_valid,
  output logic                    round_ready,
  output logic [7:0]              output_data,
  output logic                    output_valid,
  input  logic                    output_ready,
  input  logic                    result_done,
  output logic [15:0]             block_count
`ifdef HELIOS_SYNDROME_COUNT_EN
  ,
  output logic [15:0]             syndrome_count
`endif
);
  localparam int RW = GRID_WIDTH_U > 1 ? $clog2(GRID_WIDTH_U) : 1;
  state_t state_q, state_d;
  logic [RW-1:0] round_cnt_q, round_cnt_d;
  logic [15:0] block_count_q, block_count_d;
  logic out_hs, load, shift, last;
  logic [7:0] ser_byte;
  assign out_hs = output_valid && output_ready;
  assign load = state_q == ST_LOAD && round_valid;
  assign shift = state_q == ST_SEND && output_ready;
  round_byte_serializer #(.PU(PU_PER_ROUND), .BYTES(BYTES_PER_ROUND)) u_ser (
    .clk(clk),
    .reset(reset),
    .load(load),
    .shift(shift),
    .din(round_data),
    .byte_out(ser_byte),
    .last(last)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= ST_RST;
      round_cnt_q <= '0;
      block_count_q <= '0;
    end else begin
      state_q <= state_d;
      round_cnt_q <= round_cnt_d;
      block_count_q <= block_count_d;
    end
  always_comb begin
    state_d = state_q;
    round_cnt_d = round_cnt_q;
    block_count_d = block_count_q;
    case (state_q)
      ST_RST: state_d = ST_START;
      ST_START: state_d = out_hs ? ST_HEADER : ST_START;
      ST_HEADER: begin
        state_d = out_hs ? ST_LOAD : ST_HEADER;
        round_cnt_d = out_hs ? '0 : round_cnt_q;
      end
      ST_LOAD: state_d = round_valid ? ST_SEND : ST_LOAD;
      ST_SEND:
        if (out_hs && last) begin
          state_d = round_cnt_q == RW'(GRID_WIDTH_U - 1) ? ST_WAIT_RESULT : ST_LOAD;
          round_cnt_d = round_cnt_q == RW'(GRID_WIDTH_U - 1) ? round_cnt_q : round_cnt_q + RW'(1);
        end
      ST_WAIT_RESULT: begin
        state_d = result_done ? ST_HEADER : ST_WAIT_RESULT;
        block_count_d = result_done ? block_count_q + 16'd1 : block_count_q;
      end
      default: state_d = ST_RST;
    endcase
  end
  always_comb begin
    output_valid = 1'b0;
    output_data = '0;
    round_ready = 1'b0;
    case (state_q)
      ST_START: begin
        output_valid = 1'b1;
        output_data = START_DECODING_MSG;
      end
      ST_HEADER: begin
        output_valid = round_valid;
        output_data = MEASUREMENT_DATA_HEADER;
      end
      ST_LOAD: round_ready = 1'b1;
      ST_SEND: begin
        output_valid = 1'b1;
        output_data = ser_byte;
      end
      default: output_valid = 1'b0;
    endcase
  end
  assign block_count = block_count_q;
`ifdef HELIOS_SYNDROME_COUNT_EN
  logic [15:0] syn_q, syn_d, pop;
  always_comb begin
    pop = '0;
    for (int i = 0; i < PU_PER_ROUND; i++) pop = pop + 16'(round_data[i]);
    syn_d = state_q == ST_HEADER && out_hs ? '0 : load ? sat_add16(syn_q, pop) : syn_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) syn_q <= '0;
    else syn_q <= syn_d;
  assign syndrome_count = syn_q;
`endif
endmodule

// File: tb/tb_syndrome_stream_packer.sv
// tb_syndrome_stream_packer: table vectors plus random blocks against a byte-stream model of the packer
module tb_syndrome_stream_packer;
  import syndrome_stream_packer_pkg::*;
  localparam int U = 9;
  localparam int PU = 18;
  localparam int NB = 3;
  typedef struct {
    logic [PU-1:0] rnd;
    logic [7:0]    b0;
    logic [7:0]    b1;
    logic [7:0]    b2;
  } vec_t;
  logic clk = 1'b0;
  logic reset, round_valid, round_ready, output_valid, output_ready, result_done;
  logic [PU-1:0] round_data;
  logic [7:0] output_data;
  logic [15:0] block_count;
`ifdef HELIOS_SYNDROME_COUNT_EN
  logic [15:0] syndrome_count;
`endif
  int checks = 0;
  int errors = 0;
  int exp_blocks = 0;
  int exp_syn = 0;
  logic [PU-1:0] blk [U];
  logic [7:0] got0 [NB];
  vec_t tab [6];
  always #5 clk = ~clk;
  syndrome_stream_packer dut (
    .clk(clk),
    .reset(reset),
    .round_data(round_data),
    .round_valid(round_valid),
    .round_ready(round_ready),
    .output_data(output_data),
    .output_valid(output_valid),
    .output_ready(output_ready),
    .result_done(result_done),
    .block_count(block_count)
`ifdef HELIOS_SYNDROME_COUNT_EN
    ,
    .syndrome_count(syndrome_count)
`endif
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, output_valid, 0);
    check({tag, "_data"}, output_data, 0);
    check({tag, "_ready"}, round_ready, 0);
    check({tag, "_blocks"}, block_count, 0);
`ifdef HELIOS_SYNDROME_COUNT_EN
    check({tag, "_syn"}, syndrome_count, 0);
`endif
  endtask
  task automatic release_and_start();
    int nvalid;
    int first;
    nvalid = 0;
    first = -1;
    round_valid = 1'b0;
    output_ready = 1'b1;
    result_done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("release_idle", output_valid, 0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (output_valid) begin
        if (first < 0) begin
          first = c;
          check("start_data", output_data, START_DECODING_MSG);
        end
        nvalid++;
      end
    end
    check("start_cycle", first, 0);
    check("start_count", nvalid, 1);
  endtask
  task automatic pulse_done();
    @(negedge clk);
    result_done = 1'b1;
    round_valid = 1'b1;
    round_data = blk[0];
    output_ready = 1'b0;
    #1;
    check("wait_idle", output_valid, 0);
    @(negedge clk);
    result_done = 1'b0;
    exp_blocks++;
    #1;
    check("hdr_valid", output_valid, 1);
    check("hdr_data", output_data, MEASUREMENT_DATA_HEADER);
    check("block_count", block_count, exp_blocks & 16'hFFFF);
  endtask
  task automatic check_idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      round_valid = 1'b1;
      round_data = '0;
      output_ready = 1'b1;
      result_done = 1'b0;
      #1;
      check("idle_valid", output_valid, 0);
      check("idle_ready", round_ready, 0);
    end
    check("idle_blocks", block_count, exp_blocks & 16'hFFFF);
`ifdef HELIOS_SYNDROME_COUNT_EN
    check("idle_syn", syndrome_count, exp_syn);
`endif
  endtask
  // mode 0: ready always, 1: ready toggles, 2: random ready and stray result_done
  task automatic run_block(input int mode, input int abort_at);
    logic [7:0] exp_q [$];
    logic [7:0] b [NB];
    logic [7:0] pd;
    logic stall;
    int ri, got, cyc;
    exp_q = {};
    exp_q.push_back(MEASUREMENT_DATA_HEADER);
    exp_syn = 0;
    for (int r = 0; r < U; r++) begin
      for (int k = 0; k < NB; k++) b[k] = 8'h00;
      for (int n = 0; n < PU; n++) if (blk[r][n]) b[n / 8][n % 8] = 1'b1;
      for (int k = 0; k < NB; k++) exp_q.push_back(b[k]);
      exp_syn += $countones(blk[r]);
    end
    if (exp_syn > 65535) exp_syn = 65535;
    ri = 0;
    got = 0;
    cyc = 0;
    stall = 1'b0;
    pd = '0;
    while (exp_q.size() > 0 && cyc < 400) begin
      @(negedge clk);
      output_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      round_valid = ri < U;
      round_data = ri < U ? blk[ri] : '0;
      result_done = mode == 2 && $urandom_range(0, 3) == 0;
      #1;
      if (stall) begin
        check("stall_valid", output_valid, 1);
        check("stall_data", output_data, pd);
      end
      stall = output_valid && !output_ready;
      pd = output_data;
      if (output_valid && output_ready) begin
        if (got >= 1 && got <= NB) got0[got-1] = output_data;
        check("stream_byte", output_data, exp_q.pop_front());
        got++;
        if (abort_at != 0 && got == abort_at) begin
          reset = 1'b1;
          #1;
          check_reset_outputs("async_rst");
          return;
        end
      end
      if (round_valid && round_ready) ri++;
      cyc++;
    end
    check("block_bytes_left", exp_q.size(), 0);
  endtask
  initial begin
    tab[0] = '{18'h00201, 8'h01, 8'h02, 8'h00};
    tab[1] = '{18'h20000, 8'h00, 8'h00, 8'h02};
    tab[2] = '{18'h3FFFF, 8'hFF, 8'hFF, 8'h03};
    tab[3] = '{18'h2AAAA, 8'hAA, 8'hAA, 8'h02};
    tab[4] = '{18'h15555, 8'h55, 8'h55, 8'h01};
    tab[5] = '{18'h00000, 8'h00, 8'h00, 8'h00};
    reset = 1'b1;
    round_valid = 1'b0;
    round_data = '0;
    output_ready = 1'b1;
    result_done = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    release_and_start();
    for (int t = 0; t < 6; t++) begin
      for (int r = 0; r < U; r++) blk[r] = '0;
      blk[0] = tab[t].rnd;
      if (t > 0) pulse_done();
      run_block(t % 2, 0);
      check("tab_b0", got0[0], tab[t].b0);
      check("tab_b1", got0[1], tab[t].b1);
      check("tab_b2", got0[2], tab[t].b2);
      check_idle(4);
    end
    for (int t = 0; t < 3; t++) begin
      for (int r = 0; r < U; r++) blk[r] = PU'($urandom);
      pulse_done();
      run_block(2, 0);
      check_idle(3);
    end
    for (int r = 0; r < U; r++) blk[r] = PU'($urandom);
    pulse_done();
    run_block(0, 14);
    repeat (2) @(negedge clk);
    exp_blocks = 0;
    #1;
    check_reset_outputs("held_rst");
    release_and_start();
    run_block(1, 0);
    check_idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
